padding_ctrl: RTL and testbench

Frame sequencer for the padding datapath (padding + padding_reg row buffer). It drives the datapath's en, wait_en and count controls, so that 418 padded rows (top zero row, IMG_H image rows, bottom zero row) flow through the 3-row buffer. It accepts input rows from upstream via valid/ready. It presents each complete 3-row window to the downstream conv stage via valid/ready, and holds the window until that stage consumes it.

---
 rtl/padding_pkg.sv | 22 ++
 rtl/padding_perf_cnt.sv | 19 +
 rtl/padding_ctrl.sv | 133 +++++++++++++
 tb/tb_padding_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/padding_pkg.sv
// Shared definitions for the padding frame sequencer: default geometry,
// controller state encoding and the pad-row test used by the controller.
package padding_pkg;

  localparam int IMG_H_DEF = 416;
  localparam int CNT_W_DEF = 9;
  localparam int PAD_ROWS  = IMG_H_DEF + 2;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SETTLE,
    WIN,
    DONE
  } state_t;

  // The top and bottom padded rows are synthesised as zeros by the datapath.
  function automatic logic pad_row(input int unsigned row, input int unsigned img_h);
    return (row == 0) || (row == img_h + 1);
  endfunction

endpackage

// File: rtl/padding_perf_cnt.sv
// Stall-cycle counter for the padding sequencer, only instantiated when
// PADDING_CTRL_PERF_EN is defined.
module padding_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        stall,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/padding_ctrl.sv
// Frame sequencer driving the padding row buffer: pushes padded rows, waits for
// the datapath to settle and hands 3-row windows downstream. Optional macro:
// PADDING_CTRL_PERF_EN adds a stall_cnt output.
module padding_ctrl
  import padding_pkg::*;
#(
  parameter int IMG_H    = IMG_H_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PIPE_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] win_row,
  output logic             pad_en,
  output logic             pad_wait_en,
  output logic [CNT_W-1:0] pad_count,
  output logic             busy,
  output logic             done
`ifdef PADDING_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int SET_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] LAST_PAD = CNT_W'(IMG_H + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

  state_t           state;
  logic [1:0]       fill;
  logic [SET_W-1:0] settle;
  logic             cur_pad;

  assign cur_pad = pad_row(32'(pad_count), 32'(IMG_H));

  // Push handshake depends on the live in_valid, so it is decoded from state.
  always_comb begin
    in_ready = (state == FILL) && !cur_pad;
    pad_en   = (state == FILL) && (cur_pad || in_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fill        <= 2'd0;
      settle      <= '0;
      pad_count   <= '0;
      win_row     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      win_valid   <= 1'b0;
      pad_wait_en <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            pad_count <= '0;
            fill      <= 2'd0;
            win_row   <= '0;
            busy      <= 1'b1;
          end
        end
        FILL: begin
          if (pad_en) begin
            if (pad_count != LAST_PAD) pad_count <= pad_count + CNT_W'(1);
            if (fill != 2'd3) fill <= fill + 2'd1;
            // Third push completes the first window; afterwards every push does.
            if (fill >= 2'd2) begin
              state  <= SETTLE;
              settle <= '0;
            end
          end
        end
        SETTLE: begin
          if (settle == SET_LAST) begin
            state       <= WIN;
            win_valid   <= 1'b1;
            pad_wait_en <= 1'b1;
          end else begin
            settle <= settle + SET_W'(1);
          end
        end
        WIN: begin
          if (win_ready) begin
            win_valid   <= 1'b0;
            pad_wait_en <= 1'b0;
            if (win_row == LAST_ROW) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              win_row <= win_row + CNT_W'(1);
              state   <= FILL;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          pad_count <= '0;
          win_row   <= '0;
          fill      <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PADDING_CTRL_PERF_EN
  logic stall;
  logic perf_clear;

  assign stall      = ((state == FILL) && !cur_pad && !in_valid) ||
                      ((state == WIN) && !win_ready);
  assign perf_clear = (state == IDLE) && start;

  padding_perf_cnt u_perf (
    .clk       (clk),
    .reset     (reset),
    .clear     (perf_clear),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_padding_ctrl.sv
// Self-checking bench for padding_ctrl: a row/window counting model checked
// every cycle, plus directed and random frames with literal expectations.
module tb_padding_ctrl;

  localparam int IMG_H    = 4;
  localparam int CNT_W    = 9;
  localparam int PIPE_LAT = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             win_ready = 1'b0;
  logic             in_ready;
  logic             win_valid;
  logic [CNT_W-1:0] win_row;
  logic             pad_en;
  logic             pad_wait_en;
  logic [CNT_W-1:0] pad_count;
  logic             busy;
  logic             done;
`ifdef PADDING_CTRL_PERF_EN
  logic [31:0]      stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  padding_ctrl #(
    .IMG_H    (IMG_H),
    .CNT_W    (CNT_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_row     (win_row),
    .pad_en      (pad_en),
    .pad_wait_en (pad_wait_en),
    .pad_count   (pad_count),
    .busy        (busy),
    .done        (done)
`ifdef PADDING_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic st, input logic iv, input logic wr);
    reset     = rs;
    start     = st;
    in_valid  = iv;
    win_ready = wr;
  endtask

  function automatic bit is_pad(input int r);
    return (r == 0) || (r == IMG_H + 1);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Frame model: counts rows pushed and windows consumed, from the reset state.
  bit      m_active, m_fill_live, m_settling, m_win_live, m_done;
  int      m_pushes, m_windows, m_settle_left;
  int      m_stall;

  task automatic model_reset();
    m_active = 0; m_fill_live = 0; m_settling = 0; m_win_live = 0; m_done = 0;
    m_pushes = 0; m_windows = 0; m_settle_left = 0; m_stall = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      bit exp_pad_en;
      @(negedge clk);
      exp_pad_en = m_fill_live && (is_pad(m_pushes) || in_valid);
      checkOutput("busy", busy, m_active);
      checkOutput("done", done, m_done);
      checkOutput("in_ready", in_ready, m_fill_live && !is_pad(m_pushes));
      checkOutput("pad_en", pad_en, exp_pad_en);
      checkOutput("pad_count", pad_count, m_active ? imin(m_pushes, IMG_H + 1) : 0);
      checkOutput("win_valid", win_valid, m_win_live);
      checkOutput("pad_wait_en", pad_wait_en, m_win_live);
      checkOutput("win_row", win_row, m_active ? imin(m_windows, IMG_H - 1) : 0);
`ifdef PADDING_CTRL_PERF_EN
      checkOutput("stall_cnt", stall_cnt, m_stall);
`endif
      if (reset) begin
        model_reset();
      end else if (m_done) begin
        m_done = 0; m_active = 0; m_pushes = 0; m_windows = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_pushes = 0; m_windows = 0; m_fill_live = 1; m_stall = 0;
        end
      end else begin
        if ((m_fill_live && !is_pad(m_pushes) && !in_valid) || (m_win_live && !win_ready))
          m_stall++;
        if (m_fill_live && exp_pad_en) begin
          m_pushes++;
          if (m_pushes == m_windows + 3) begin
            m_fill_live = 0; m_settling = 1; m_settle_left = PIPE_LAT;
          end
        end else if (m_settling) begin
          m_settle_left--;
          if (m_settle_left == 0) begin
            m_settling = 0; m_win_live = 1;
          end
        end else if (m_win_live && win_ready) begin
          m_windows++;
          m_win_live = 0;
          if (m_windows == IMG_H) m_done = 1;
          else m_fill_live = 1;
        end
      end
    end
  end

  // Modes: 0 full rate, 1 input+window stalls, 2 reset at window 2,
  // 3 start re-pulsed while busy, 4 random handshakes.
  task automatic run_frame(input int mode, input int budget, output int done_cycle,
                           output int first_win, output int n_push, output int n_in_hs,
                           output int n_win_hs);
    int iv_stall = 3;
    int wr_stall = 5;
    done_cycle = -1; first_win = -1; n_push = 0; n_in_hs = 0; n_win_hs = 0;
    for (int c = 0; c < budget; c++) begin
      logic st, rs, iv, wr;
      st = (c == 0) || (mode == 3 && (c == 7 || c == 12));
      rs = 1'b0; iv = 1'b1; wr = 1'b1;
      if (mode == 4) begin
        iv = ($urandom_range(0, 3) != 0);
        wr = ($urandom_range(0, 3) != 0);
      end
      if (mode == 1 && in_ready && pad_count == 2 && iv_stall > 0) begin
        iv = 1'b0; iv_stall--;
      end
      if (mode == 1 && win_valid && win_row == 1 && wr_stall > 0) begin
        wr = 1'b0; wr_stall--;
      end
      if (mode == 2 && win_valid && win_row == 2) begin
        rs = 1'b1; wr = 1'b0;
      end
      applyStimulus(rs, st, iv, wr);
      @(negedge clk);
      if (pad_en) n_push++;
      if (in_ready && in_valid) n_in_hs++;
      if (win_valid && win_ready) n_win_hs++;
      if (win_valid && first_win < 0) first_win = c;
      if (done && done_cycle < 0) done_cycle = c;
      @(posedge clk);
      #1;
      if (rs || done_cycle >= 0) break;
    end
  endtask

  initial begin
    int dc, fw, np, nih, nwh;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_pad_count", pad_count, 0);
    @(posedge clk);
    #1;

    run_frame(0, 100, dc, fw, np, nih, nwh);
    checkOutput("s1_first_win", fw, 5);
    checkOutput("s1_done_cycle", dc, 15);
    checkOutput("s1_pushes", np, IMG_H + 2);
    checkOutput("s1_in_hs", nih, IMG_H);
    checkOutput("s1_win_hs", nwh, IMG_H);

    run_frame(1, 100, dc, fw, np, nih, nwh);
    checkOutput("s23_first_win", fw, 8);
    checkOutput("s23_done_cycle", dc, 23);
    checkOutput("s23_pushes", np, IMG_H + 2);
    checkOutput("s23_in_hs", nih, IMG_H);
    checkOutput("s23_win_hs", nwh, IMG_H);
`ifdef PADDING_CTRL_PERF_EN
    checkOutput("s6_stall_cnt", stall_cnt, 8);
`endif

    run_frame(3, 100, dc, fw, np, nih, nwh);
    checkOutput("s5_done_cycle", dc, 15);
    checkOutput("s5_win_hs", nwh, IMG_H);

    run_frame(2, 100, dc, fw, np, nih, nwh);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("s4_no_done", (dc < 0), 1);
    checkOutput("s4_busy", busy, 0);
    checkOutput("s4_win_valid", win_valid, 0);
    checkOutput("s4_win_row", win_row, 0);
    @(posedge clk);
    #1;
    run_frame(0, 100, dc, fw, np, nih, nwh);
    checkOutput("s4_restart_done", dc, 15);
    checkOutput("s4_restart_win_hs", nwh, IMG_H);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("s5_rst_start_busy", busy, 0);
    checkOutput("s5_rst_start_pad_en", pad_en, 0);
    @(posedge clk);
    #1;

    repeat (6) begin
      run_frame(4, 400, dc, fw, np, nih, nwh);
      checkOutput("rand_done_seen", (dc >= 0), 1);
      checkOutput("rand_pushes", np, IMG_H + 2);
      checkOutput("rand_in_hs", nih, IMG_H);
      checkOutput("rand_win_hs", nwh, IMG_H);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
